// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// 640x480@60 Hz VGA raster timing generator running from the 50 MHz system
// clock. A divide-by-two pixel enable drives the horizontal/vertical
// counters. The syncs and blank are decoded from the next-state counters and
// registered, so they change on the same edge as DrawX/DrawY. line_end and
// frame_start strobes are provided for per-line and per-frame game logic.
//
// Optional build macro: VGA_TIMING_PIPE_EN
//   When defined, VGA_HS, VGA_VS and VGA_BLANK_N pass through one extra
//   pixel-enabled register stage. They then lag DrawX/DrawY by one pixel,
//   which lines them up with a registered colour-mapper output.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33
) (
  input  logic       Clk,
  input  logic       Reset,
  output logic       VGA_CLK,
  output logic       pix_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       line_end,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  // Current state
  logic       pix_en_q;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_r;
  logic       vs_r;
  logic       blank_n_r;
  logic       line_end_r;
  logic       frame_start_r;

  // Next state
  logic       pix_en_d;
  logic [9:0] hc_d;
  logic [9:0] vc_d;
  logic       hs_d;
  logic       vs_d;
  logic       blank_n_d;
  logic       line_end_d;
  logic       frame_start_d;

  // Pixel enable toggles each clock; counters advance only when it is high.
  always_comb begin
    // NOTE: every signal gets a default before the branches, so no path
    // leaves a value unassigned and no latch is inferred.
    pix_en_d = ~pix_en_q;
    hc_d     = hc;
    vc_d     = vc;
    if (pix_en_q) begin
      if (hc == H_LAST) begin
        hc_d = '0;
        vc_d = (vc == V_LAST) ? '0 : vc + 10'd1;
      end else begin
        hc_d = hc + 10'd1;
      end
    end
  end

  // Decode syncs, blank and strobes from the next-state counters so the
  // registered versions line up with the registered DrawX/DrawY.
  always_comb begin
    hs_d          = ~((hc_d >= HS_START) && (hc_d < HS_END));
    vs_d          = ~((vc_d >= VS_START) && (vc_d < VS_END));
    blank_n_d     = (hc_d < H_VIS) && (vc_d < V_VIS);
    line_end_d    = pix_en_d && (hc_d == H_LAST);
    frame_start_d = line_end_d && (vc_d == V_LAST);
  end

  // State register with asynchronous reset back to the top-left idle state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_en_q      <= 1'b0;
      hc            <= '0;
      vc            <= '0;
      hs_r          <= 1'b1;
      vs_r          <= 1'b1;
      blank_n_r     <= 1'b0;
      line_end_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      pix_en_q      <= pix_en_d;
      hc            <= hc_d;
      vc            <= vc_d;
      hs_r          <= hs_d;
      vs_r          <= vs_d;
      blank_n_r     <= blank_n_d;
      line_end_r    <= line_end_d;
      frame_start_r <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_PIPE_EN
  logic hs_p;
  logic vs_p;
  logic blank_n_p;

  // Extra pixel-enabled stage: syncs and blank trail DrawX/DrawY by one pixel.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hs_p      <= 1'b1;
      vs_p      <= 1'b1;
      blank_n_p <= 1'b0;
    end else if (pix_en_q) begin
      hs_p      <= hs_r;
      vs_p      <= vs_r;
      blank_n_p <= blank_n_r;
    end
  end

  assign VGA_HS      = hs_p;
  assign VGA_VS      = vs_p;
  assign VGA_BLANK_N = blank_n_p;
`else
  assign VGA_HS      = hs_r;
  assign VGA_VS      = vs_r;
  assign VGA_BLANK_N = blank_n_r;
`endif

  assign VGA_CLK     = pix_en_q;
  assign pix_en      = pix_en_q;
  assign DrawX       = hc;
  assign DrawY       = vc;
  assign VGA_SYNC_N  = 1'b0;
  assign line_end    = line_end_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// Runs two instances side by side: the full 640x480 timing, and a tiny raster
// (15x9 total) so that whole frames, vertical sync and frame_start fit in a
// short run. A closed-form model maps the number of clock edges since reset
// release to the expected outputs; it is compared every cycle. Resets are
// asserted at random instants and random intervals.
module tb_vga_timing_gen;

  typedef struct {
    int h_vis, h_fp, h_sw, h_bp;
    int v_vis, v_fp, v_sw, v_bp;
  } tim_t;

  typedef struct {
    logic       pe;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       bn;
    logic       le;
    logic       fs;
  } exp_t;

`ifdef VGA_TIMING_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam int PO = 2 * PIPE;  // sync/blank lag, in clocks

  tim_t ta = '{640, 16, 96, 48, 480, 10, 2, 33};
  tim_t tb = '{8, 2, 3, 2, 4, 1, 2, 2};

  logic clk;
  logic rst;

  logic       a_vga_clk, a_pe, a_hs, a_vs, a_bn, a_sn, a_le, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_vga_clk, b_pe, b_hs, b_vs, b_bn, b_sn, b_le, b_fs;
  logic [9:0] b_x, b_y;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int n;            // clock edges since reset release
  int cyc = 0;
  int last_le_a = -1, hs_low_a = 0;
  int last_fs_b = -1, vs_low_b = 0;

  vga_timing_gen dut_a (
    .Clk(clk), .Reset(rst), .VGA_CLK(a_vga_clk), .pix_en(a_pe),
    .DrawX(a_x), .DrawY(a_y), .VGA_HS(a_hs), .VGA_VS(a_vs),
    .VGA_BLANK_N(a_bn), .VGA_SYNC_N(a_sn), .line_end(a_le),
    .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)
  ) dut_b (
    .Clk(clk), .Reset(rst), .VGA_CLK(b_vga_clk), .pix_en(b_pe),
    .DrawX(b_x), .DrawY(b_y), .VGA_HS(b_hs), .VGA_VS(b_vs),
    .VGA_BLANK_N(b_bn), .VGA_SYNC_N(b_sn), .line_end(b_le),
    .frame_start(b_fs)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) n <= 0;
    else     n <= n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Expected outputs after n clock edges: n/2 pixels have elapsed.
  function automatic exp_t model(input int edges, input tim_t t);
    exp_t e;
    int ht, vt, p, dp, hx, hy;
    ht = t.h_vis + t.h_fp + t.h_sw + t.h_bp;
    vt = t.v_vis + t.v_fp + t.v_sw + t.v_bp;
    e.pe = 1'b0; e.x = '0; e.y = '0;
    e.hs = 1'b1; e.vs = 1'b1; e.bn = 1'b0; e.le = 1'b0; e.fs = 1'b0;
    if (edges == 0) return e;
    p    = edges / 2;
    e.pe = (edges % 2) == 1;
    e.x  = 10'(p % ht);
    e.y  = 10'((p / ht) % vt);
    e.le = e.pe && ((p % ht) == ht - 1);
    e.fs = e.le && (((p / ht) % vt) == vt - 1);
    dp = p - PIPE;
    if (dp >= 0) begin
      hx = dp % ht;
      hy = (dp / ht) % vt;
      e.hs = !(hx >= t.h_vis + t.h_fp && hx < t.h_vis + t.h_fp + t.h_sw);
      e.vs = !(hy >= t.v_vis + t.v_fp && hy < t.v_vis + t.v_fp + t.v_sw);
      e.bn = (hx < t.h_vis) && (hy < t.v_vis);
    end
    return e;
  endfunction

  task automatic cmp_out(input string tag, input exp_t e, input logic pe, input logic vclk,
                         input logic [9:0] x, input logic [9:0] y, input logic hs,
                         input logic vs, input logic bn, input logic sn,
                         input logic le, input logic fs);
    check({tag, "_pix_en"}, pe, e.pe);
    check({tag, "_vga_clk"}, vclk, e.pe);
    check({tag, "_drawx"}, x, e.x);
    check({tag, "_drawy"}, y, e.y);
    check({tag, "_hs"}, hs, e.hs);
    check({tag, "_vs"}, vs, e.vs);
    check({tag, "_blank_n"}, bn, e.bn);
    check({tag, "_sync_n"}, sn, 0);
    check({tag, "_line_end"}, le, e.le);
    check({tag, "_frame_start"}, fs, e.fs);
  endtask

  // Per-cycle comparison against the model, plus literal period/edge pins.
  always @(negedge clk) begin
    cyc++;
    cmp_out("a", model(n, ta), a_pe, a_vga_clk, a_x, a_y, a_hs, a_vs, a_bn, a_sn, a_le, a_fs);
    cmp_out("b", model(n, tb), b_pe, b_vga_clk, b_x, b_y, b_hs, b_vs, b_bn, b_sn, b_le, b_fs);
    check("a_x_range", a_x <= 10'd799 && a_y <= 10'd524, 1);
    if (rst) begin
      last_le_a = -1; hs_low_a = 0;
      last_fs_b = -1; vs_low_b = 0;
    end else begin
      if (a_hs === 1'b0) hs_low_a++;
      if (a_le === 1'b1) begin
        if (last_le_a >= 0) begin
          check("a_line_period", cyc - last_le_a, 1600);
          check("a_hs_low_clks", hs_low_a, 192);
        end
        last_le_a = cyc; hs_low_a = 0;
      end
      if (b_vs === 1'b0) vs_low_b++;
      if (b_fs === 1'b1) begin
        if (last_fs_b >= 0) begin
          check("b_frame_period", cyc - last_fs_b, 270);
          check("b_vs_low_clks", vs_low_b, 60);
        end
        last_fs_b = cyc; vs_low_b = 0;
      end
      if (n == 2*655 + PO) check("a_hs_before_fall", a_hs, 1);
      if (n == 2*656 + PO) begin
        check("a_hs_fall", a_hs, 0);
        check("a_hs_fall_x", a_x, 656 + PIPE);
      end
      if (n == 2*751 + PO) check("a_hs_before_rise", a_hs, 0);
      if (n == 2*752 + PO) begin
        check("a_hs_rise", a_hs, 1);
        check("a_hs_rise_x", a_x, 752 + PIPE);
      end
      if (n == 2*639 + PO) check("a_blank_639_0", a_bn, 1);
      if (n == 2*640 + PO) begin
        check("a_blank_640_0", a_bn, 0);
        check("a_blank_fall_x", a_x, 640 + PIPE);
      end
      if (n == 1 + PO)     check("b_blank_0_0", b_bn, 1);
      if (n == 2*52 + PO)  check("b_blank_7_3", b_bn, 1);
      if (n == 2*53 + PO)  check("b_blank_8_3", b_bn, 0);
      if (n == 2*60 + PO)  check("b_blank_0_4", b_bn, 0);
      if (n == 2*75 - 1 + PO) check("b_vs_before_fall", b_vs, 1);
      if (n == 2*75 + PO)  check("b_vs_fall", b_vs, 0);
    end
  end

  task automatic chk_reset_now();
    check("rst_a_pix_en", a_pe, 0);
    check("rst_a_vga_clk", a_vga_clk, 0);
    check("rst_a_drawx", a_x, 0);
    check("rst_a_drawy", a_y, 0);
    check("rst_a_hs", a_hs, 1);
    check("rst_a_vs", a_vs, 1);
    check("rst_a_blank_n", a_bn, 0);
    check("rst_a_line_end", a_le, 0);
    check("rst_a_frame_start", a_fs, 0);
    check("rst_b_drawx", b_x, 0);
    check("rst_b_drawy", b_y, 0);
    check("rst_b_vs", b_vs, 1);
  endtask

  // Assert reset between edges, confirm it took effect without a clock edge,
  // hold for a few cycles and release away from the active edge.
  task automatic pulse_reset(input bool_pos_phase, input int off, input int hold);
    if (bool_pos_phase) @(posedge clk);
    else                @(negedge clk);
    #(off);
    rst = 1'b1;
    #1;
    chk_reset_now();
    repeat (hold) @(negedge clk);
    #3;
    rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #3;
    rst = 1'b0;
    repeat (5000) @(negedge clk);

    // Fresh start, then reset mid-line at DrawX=300 on line 1.
    pulse_reset(0, 5, 2);
    guard = 0;
    while (n != 2*(800 + 300) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("a_x_before_midline_rst", a_x, 300);
    check("a_y_before_midline_rst", a_y, 1);
    #3;
    rst = 1'b1;
    #1;
    chk_reset_now();
    repeat (2) @(negedge clk);
    #3;
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("a_restart_x", a_x, k / 2);
      check("a_restart_no_fs", a_fs, 0);
      check("b_restart_no_fs", b_fs, 0);
    end

    // Random reset episodes at random points of the raster.
    for (int ep = 0; ep < 6; ep++) begin
      repeat ($urandom_range(200, 3000)) @(negedge clk);
      pulse_reset($urandom_range(0, 1), $urandom_range(1, 8), $urandom_range(1, 3));
    end

    repeat (2000) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
